// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Registers the execute results, runs a load/store through a ready/request
// data-memory handshake, stalls upstream while the access is outstanding,
// emits a one-cycle retire beat, and forwards taken-branch redirects.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        stall_flag,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_error
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  wait_cnt;
    logic [4:0]  held_rd;
    logic        held_reg_write;
    logic        held_mem_to_reg;

    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic        start;
    logic        done;
    logic        expire;

    assign is_mem     = mem_read | mem_write;
    assign misaligned = |alu_result[1:0];
    assign stall_flag = (state == ACCESS);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    accept = 1'b1;
                    if (is_mem && !misaligned) begin
                        start    = 1'b1;
                        state_nx = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    expire   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Wait counter: cleared on issue, counts ACCESS cycles without ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (start)
            wait_cnt <= '0;
        else if (stall_flag && !dmem_ready && !expire)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Memory request, retire beat, branch redirect and sticky error.
    // dmem_addr doubles as the latched ALU result for the retire data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            held_rd         <= '0;
            held_reg_write  <= 1'b0;
            held_mem_to_reg <= 1'b0;
            wb_valid        <= 1'b0;
            wb_reg_write    <= 1'b0;
            wb_rd           <= '0;
            wb_data         <= '0;
            pc_src          <= 1'b0;
            pc_target       <= '0;
            mem_error       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;

            if (accept) begin
                if (branch_taken) begin
                    pc_src    <= 1'b1;
                    pc_target <= branch_target;
                end
                if (start) begin
                    // Both read and write set behaves as a store.
                    dmem_req        <= 1'b1;
                    dmem_we         <= mem_write;
                    dmem_addr       <= alu_result;
                    dmem_wdata      <= store_data;
                    held_rd         <= rd_in;
                    held_reg_write  <= reg_write;
                    held_mem_to_reg <= mem_to_reg;
                end else begin
                    // Non-memory or misaligned: retire on the next edge.
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_in;
                    wb_data      <= alu_result;
                    wb_reg_write <= reg_write & ~is_mem;
                    if (is_mem) mem_error <= 1'b1;
                end
            end

            if (done) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= held_rd;
                wb_data      <= held_mem_to_reg ? dmem_rdata : dmem_addr;
                wb_reg_write <= held_reg_write & ~dmem_we;
            end

            if (expire) begin
                dmem_req     <= 1'b0;
                mem_error    <= 1'b1;
                wb_valid     <= 1'b1;
                wb_rd        <= held_rd;
                wb_data      <= dmem_addr;
                wb_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall_flag, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_error;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall_flag(stall_flag),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_src(pc_src), .pc_target(pc_target), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rd_m, input logic wr_m, input logic rw, input logic m2r);
        valid_in   = v;
        alu_result = alu;
        rd_in      = rd;
        mem_read   = rd_m;
        mem_write  = wr_m;
        reg_write  = rw;
        mem_to_reg = m2r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        store_data = '0; branch_taken = 1'b0; branch_target = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        #3;
        // Reset state
        chk("rst_stall", 32'(stall_flag), 32'd0);
        chk("rst_req",   32'(dmem_req),   32'd0);
        chk("rst_wbv",   32'(wb_valid),   32'd0);
        chk("rst_wbd",   wb_data,         32'd0);
        chk("rst_err",   32'(mem_error),  32'd0);
        chk("rst_pcs",   32'(pc_src),     32'd0);
        #9 reset = 1'b1;

        // Non-memory instruction
        drive(1'b1, 32'h10, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("alu_wbv", 32'(wb_valid),     32'd1);
        chk("alu_wbd", wb_data,           32'h10);
        chk("alu_rd",  32'(wb_rd),        32'd3);
        chk("alu_rw",  32'(wb_reg_write), 32'd1);
        chk("alu_stl", 32'(stall_flag),   32'd0);
        valid_in = 1'b0;
        tick();
        chk("alu_wbv0",  32'(wb_valid), 32'd0);
        chk("alu_hold",  wb_data,       32'h10);

        // Load, ready in the third ACCESS cycle; valid_in ignored meanwhile
        drive(1'b1, 32'h40, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_rdata = 32'hDEADBEEF;
        tick();
        drive(1'b1, 32'h999, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        branch_taken = 1'b1; branch_target = 32'h999;
        chk("ld_stl1", 32'(stall_flag), 32'd1);
        chk("ld_req",  32'(dmem_req),   32'd1);
        chk("ld_we",   32'(dmem_we),    32'd0);
        chk("ld_addr", dmem_addr,       32'h40);
        chk("ld_wbv",  32'(wb_valid),   32'd0);
        tick();
        chk("ld_stl2", 32'(stall_flag), 32'd1);
        chk("ld_pcs",  32'(pc_src),     32'd0);
        tick();
        chk("ld_stl3", 32'(stall_flag), 32'd1);
        dmem_ready = 1'b1;
        tick();
        valid_in = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b0;
        chk("ld_wbv1", 32'(wb_valid),     32'd1);
        chk("ld_wbd",  wb_data,           32'hDEADBEEF);
        chk("ld_rd",   32'(wb_rd),        32'd5);
        chk("ld_rw",   32'(wb_reg_write), 32'd1);
        chk("ld_stl0", 32'(stall_flag),   32'd0);
        chk("ld_req0", 32'(dmem_req),     32'd0);
        chk("ld_pcs0", 32'(pc_src),       32'd0);

        // Store, ready in the first ACCESS cycle; stores never write rf
        drive(1'b1, 32'h8, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        store_data = 32'h1234;
        tick();
        valid_in = 1'b0;
        chk("st_we",   32'(dmem_we),    32'd1);
        chk("st_addr", dmem_addr,       32'h8);
        chk("st_wd",   dmem_wdata,      32'h1234);
        chk("st_stl",  32'(stall_flag), 32'd1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("st_wbv",  32'(wb_valid),     32'd1);
        chk("st_rw",   32'(wb_reg_write), 32'd0);
        chk("st_wbd",  wb_data,           32'h8);
        chk("st_stl0", 32'(stall_flag),   32'd0);
        chk("st_err",  32'(mem_error),    32'd0);

        // Misaligned load
        drive(1'b1, 32'h42, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("mis_req", 32'(dmem_req),     32'd0);
        chk("mis_stl", 32'(stall_flag),   32'd0);
        chk("mis_err", 32'(mem_error),    32'd1);
        chk("mis_wbv", 32'(wb_valid),     32'd1);
        chk("mis_rw",  32'(wb_reg_write), 32'd0);
        chk("mis_wbd", wb_data,           32'h42);

        // Timeout after four ACCESS cycles
        drive(1'b1, 32'h80, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stl%0d", i), 32'(stall_flag), 32'd1);
            chk($sformatf("to_req%0d", i), 32'(dmem_req),   32'd1);
            tick();
        end
        chk("to_req0", 32'(dmem_req),     32'd0);
        chk("to_stl0", 32'(stall_flag),   32'd0);
        chk("to_wbv",  32'(wb_valid),     32'd1);
        chk("to_rw",   32'(wb_reg_write), 32'd0);
        chk("to_err",  32'(mem_error),    32'd1);

        // Stray ready while idle is ignored
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("rdy_idle_wbv", 32'(wb_valid),   32'd0);
        chk("rdy_idle_stl", 32'(stall_flag), 32'd0);

        // Next non-memory instruction after the fault proceeds normally
        drive(1'b1, 32'h77, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("post_wbv", 32'(wb_valid),     32'd1);
        chk("post_wbd", wb_data,           32'h77);
        chk("post_rw",  32'(wb_reg_write), 32'd1);
        chk("post_err", 32'(mem_error),    32'd1);

        // Branch redirect pulse
        drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        valid_in = 1'b0; branch_taken = 1'b0;
        chk("br_pcs",  32'(pc_src), 32'd1);
        chk("br_tgt",  pc_target,   32'h200);
        tick();
        chk("br_pcs0", 32'(pc_src), 32'd0);
        chk("br_hold", pc_target,   32'h200);

        // Reset asserted mid-ACCESS
        drive(1'b1, 32'h40, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("mr_stl1", 32'(stall_flag), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mr_req",  32'(dmem_req),   32'd0);
        chk("mr_stl",  32'(stall_flag), 32'd0);
        chk("mr_addr", dmem_addr,       32'd0);
        chk("mr_wbd",  wb_data,         32'd0);
        chk("mr_tgt",  pc_target,       32'd0);
        chk("mr_err",  32'(mem_error),  32'd0);
        #2 reset = 1'b1;
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("mr_nobeat", 32'(wb_valid), 32'd0);
        drive(1'b1, 32'h10, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("mr_wbv", 32'(wb_valid), 32'd1);
        chk("mr_wbd", wb_data,       32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly downstream of the execution stage. It registers the ALU result, destination register and control bits and performs a load or store through a ready/request data-memory handshake. While an access is pending it holds the upstream stages with `stall_flag`. It then hands a single-cycle retire beat to write-back, and it forwards taken-branch redirects to fetch.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of ACCESS cycles spent waiting for `dmem_ready` before the access is aborted. Legal range is 2..255.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `valid_in`, in, 1: an instruction from the execute stage is present this cycle.
- `alu_result`, in, 32: ALU result, which is also the effective address for loads and stores.
- `store_data`, in, 32: rt value to be written on a store.
- `rd_in`, in, 5: destination register.
- `mem_read`, in, 1: instruction is a load.
- `mem_write`, in, 1: instruction is a store.
- `reg_write`, in, 1: instruction writes the register file.
- `mem_to_reg`, in, 1: write-back data is taken from memory rather than from the ALU.
- `branch_taken`, in, 1: branch condition is met.
- `branch_target`, in, 32: branch destination PC.
- `stall_flag`, out, 1: holds the upstream stages. Combinational, equal to (state == ACCESS).
- `dmem_req`, out, 1: data-memory request.
- `dmem_we`, out, 1: 1 = write, 0 = read.
- `dmem_addr`, out, 32: word address.
- `dmem_wdata`, out, 32: store data.
- `dmem_ready`, in, 1: memory completes the current request.
- `dmem_rdata`, in, 32: load data, valid while `dmem_ready` = 1.
- `wb_valid`, out, 1: one-cycle retire beat to write-back.
- `wb_reg_write`, out, 1: register-file write enable.
- `wb_rd`, out, 5: destination register.
- `wb_data`, out, 32: value to write.
- `pc_src`, out, 1: one-cycle redirect pulse to fetch.
- `pc_target`, out, 32: redirect address.
- `mem_error`, out, 1: sticky fault flag, set by a misaligned access or a timeout.

## Operation
State machine states:
- **IDLE**: accepts a new instruction on every edge where `valid_in` = 1.
- **ACCESS**: a memory request is outstanding.

Acceptance in IDLE (`valid_in` = 1):
- **Non-memory instruction** (`mem_read` = `mem_write` = 0):
  - At the next edge: `wb_valid` = 1, `wb_data` = `alu_result`, `wb_reg_write` = `reg_write`, `wb_rd` = `rd_in`.
  - State stays IDLE.
- **Memory instruction with `alu_result[1:0]` = 0**:
  - Latch `dmem_addr` = `alu_result`, `dmem_we` = `mem_write` and `dmem_wdata` = `store_data`.
  - Set `dmem_req` = 1, reset the wait counter to 0 and go to ACCESS.
  - `rd_in` and the control bits are latched internally.
- **Memory instruction with `alu_result[1:0]` ≠ 0 (misaligned)**:
  - No request is issued and `mem_error` is set.
  - Retire at the next edge with `wb_reg_write` = 0 and `wb_data` = `alu_result`.
- **Both `mem_read` and `mem_write` = 1**: treated as a store.

Behaviour in ACCESS:
- `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable until completion.
- `valid_in` is ignored; upstream is held by `stall_flag`.
- **Edge with `dmem_ready` = 1**:
  - `dmem_req` drops to 0 and the state returns to IDLE.
  - The retire beat is presented with `wb_data` = `mem_to_reg` ? `dmem_rdata` : latched `alu_result`.
  - `wb_reg_write` = latched `reg_write` AND NOT latched `mem_write`; stores never write the register file.
- **Otherwise**: the wait counter increments. When it reaches `TIMEOUT` − 1 without ready:
  - `dmem_req` drops, `mem_error` is set and the state returns to IDLE.
  - The instruction retires with `wb_reg_write` = 0.

Branch handling:
- An accepted instruction with `branch_taken` = 1 gives `pc_src` = 1 and `pc_target` = `branch_target` for exactly one cycle after the acceptance edge.
- The branch pulse is independent of any memory access.

Outputs outside their active cycles:
- `wb_valid` and `pc_src` are 0 outside their single active cycle.
- `wb_*` and `pc_target` keep their last values.

## Timing
- **Reset** (`reset` = 0, asynchronous): all outputs are 0 and the state is IDLE.
  - This includes `dmem_req`, `stall_flag`, `wb_*`, `pc_*`, `mem_error` and every data bus.
  - Reset asserted during ACCESS drops `dmem_req` immediately and discards the instruction. No retire beat is produced.
- **Latency**:
  - Non-memory or misaligned instruction: 1 edge.
  - Memory instruction: 1 + N edges, where N ≥ 1 is the number of ACCESS cycles up to and including the ready cycle.
- **Minimum access**: ready asserted in the first ACCESS cycle gives `stall_flag` high for 1 cycle and `wb_valid` at edge 2.
- **`dmem_ready` while `dmem_req` = 0**: ignored.
- **Back-to-back**: an instruction can be accepted on the same edge that an access completes only if the state was IDLE at that edge. Because the state is ACCESS, the next instruction is accepted on the following edge.
- **`mem_error`**: stays at 1 until reset. Subsequent instructions proceed normally.

## Test plan
- **Reset**: drive `reset` low mid-ACCESS → `dmem_req`, `stall_flag` and all outputs are 0 immediately. After release, `valid_in` with `alu_result` = 0x10 and a non-memory instruction → `wb_valid` = 1 and `wb_data` = 0x10 one edge later.
- **Load, ready after 3 cycles**: `alu_result` = 0x40, `mem_read` = `mem_to_reg` = `reg_write` = 1, `rd_in` = 5, `dmem_rdata` = 0xDEADBEEF → `stall_flag` high for 3 cycles, then `wb_valid` = 1, `wb_rd` = 5, `wb_data` = 0xDEADBEEF, `wb_reg_write` = 1.
- **Store, ready in the first cycle**: `alu_result` = 0x8, `store_data` = 0x1234 → `dmem_we` = 1, `dmem_addr` = 0x8, `dmem_wdata` = 0x1234, `stall_flag` high for 1 cycle, then `wb_valid` = 1 with `wb_reg_write` = 0.
- **Misaligned load**: `alu_result` = 0x42 → `dmem_req` stays 0, `mem_error` = 1, `wb_valid` = 1 with `wb_reg_write` = 0 after 1 edge.
- **Timeout**: `TIMEOUT` = 4, `dmem_ready` held at 0 → `dmem_req` drops after 4 ACCESS cycles, `mem_error` = 1, retire with `wb_reg_write` = 0, and the next non-memory instruction completes normally.
- **Branch**: `branch_taken` = 1, `branch_target` = 0x200 → `pc_src` = 1 and `pc_target` = 0x200 for exactly one cycle, with `pc_src` back to 0 on the following cycle.
